// File: rtl/bec_la_host.sv
// rtl/bec_la_host.sv - host sequencer that streams operands to the BEC slave and reads back wout/zout
// Chunked write, start, poll, four-word readback; every wait is bounded by TIMEOUT.
module bec_la_host #(
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start,
  input  logic [162:0] op_w1,
  input  logic [162:0] op_z1,
  input  logic [162:0] op_w2,
  input  logic [162:0] op_z2,
  input  logic [162:0] op_inv_w0,
  input  logic [162:0] op_d,
  input  logic [162:0] op_key,
  input  logic [127:0] slv_data,
  output logic [127:0] host_data,
  output logic [127:0] host_oenb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [2:0]   err_code,
  output logic [162:0] wout,
  output logic [162:0] zout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WRITE, S_START, S_WAITP, S_READ, S_FIN, S_ERR
  } state_t;

  localparam logic [15:0] CMD_ARM = 16'hAB30;
  localparam logic [15:0] CMD_GO  = 16'hAB41;
  localparam logic [15:0] CMD_RD0 = 16'hAB00;
  localparam logic [15:0] CMD_FIN = 16'hAB10;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t       state;
  logic [3:0]   idx;
  logic [3:0]   idx_nxt;
  logic [1:0]   rd_idx;
  logic [1:0]   rd_nxt;
  logic [1:0]   fin_cnt;
  logic [15:0]  wait_cnt;
  logic [162:0] opr [7];
  logic [162:0] w_sh;
  logic [162:0] z_sh;

  logic         ack_chunk;
  logic         advance;
  logic [2:0]   fail_code;
  logic [13:0]  hdr;
  logic         tmo;
  logic         unused_bits;

  function automatic logic [127:0] cmd_word(input logic [15:0] cmd);
    return {96'b0, cmd, 16'b0};
  endfunction

  // The chunk field spans [81:0], so while writing it overlays the command field.
  function automatic logic [127:0] chunk_word(input logic [3:0] i, input logic [162:0] op);
    logic [13:0] therm;
    logic [81:0] chunk;
    therm = ~(14'h3FFF << (i + 4'd1));
    chunk = i[0] ? op[81:0] : {1'b0, op[162:82]};
    return {32'b0, therm, chunk};
  endfunction

  assign hdr         = slv_data[127:114];
  assign idx_nxt     = idx + 4'd1;
  assign rd_nxt      = rd_idx + 2'd1;
  assign tmo         = (wait_cnt == TO_LAST);
  assign unused_bits = ^slv_data[31:0];

  always_comb begin
    if (idx == 4'd13) ack_chunk = (slv_data[127:122] == 6'b011110);
    else              ack_chunk = (slv_data[125:122] == idx_nxt);
  end

  // fail_code doubles as the "this is a bounded wait state" marker.
  always_comb begin
    advance   = 1'b0;
    fail_code = 3'd0;
    case (state)
      S_ARM: begin
        advance   = (slv_data[127:122] == 6'b010000) || ack_chunk;
        fail_code = 3'd1;
      end
      S_WRITE: begin
        advance   = ack_chunk;
        fail_code = 3'd2;
      end
      S_START: begin
        advance   = (slv_data[127:122] == 6'b100111);
        fail_code = 3'd3;
      end
      S_WAITP: begin
        advance   = (hdr == 14'h3100);
        fail_code = 3'd4;
      end
      S_READ: begin
        advance   = (hdr == 14'h3100 + {4'b0, rd_idx, 8'h00});
        fail_code = 3'd5;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      rd_idx    <= 2'd0;
      fin_cnt   <= 2'd0;
      wait_cnt  <= 16'd0;
      for (int k = 0; k < 7; k++) opr[k] <= '0;
      w_sh      <= '0;
      z_sh      <= '0;
      host_data <= '0;
      host_oenb <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 3'd0;
      wout      <= '0;
      zout      <= '0;
    end else begin
      done <= 1'b0;
      if (fail_code != 3'd0 && !advance && tmo) begin
        state     <= S_ERR;
        err       <= 1'b1;
        err_code  <= fail_code;
        busy      <= 1'b0;
        host_oenb <= '1;
        host_data <= '0;
        wait_cnt  <= 16'd0;
      end else begin
        if (fail_code != 3'd0) wait_cnt <= advance ? 16'd0 : wait_cnt + 16'd1;
        case (state)
          S_IDLE: begin
            if (start && !done) begin
              opr[0]    <= op_w1;
              opr[1]    <= op_z1;
              opr[2]    <= op_w2;
              opr[3]    <= op_z2;
              opr[4]    <= op_inv_w0;
              opr[5]    <= op_d;
              opr[6]    <= op_key;
              busy      <= 1'b1;
              host_oenb <= '0;
              err       <= 1'b0;
              err_code  <= 3'd0;
              idx       <= 4'd0;
              rd_idx    <= 2'd0;
              wait_cnt  <= 16'd0;
              host_data <= cmd_word(CMD_ARM);
              state     <= S_ARM;
            end
          end
          S_ARM: begin
            if (advance) begin
              idx       <= 4'd0;
              host_data <= chunk_word(4'd0, opr[0]);
              state     <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (advance) begin
              if (idx == 4'd13) begin
                host_data <= cmd_word(CMD_GO);
                state     <= S_START;
              end else begin
                idx       <= idx_nxt;
                host_data <= chunk_word(idx_nxt, opr[idx_nxt[3:1]]);
              end
            end
          end
          S_START: begin
            if (advance) begin
              host_data <= cmd_word(CMD_RD0);
              state     <= S_WAITP;
            end
          end
          S_WAITP: begin
            if (advance) begin
              rd_idx    <= 2'd0;
              host_data <= cmd_word(CMD_RD0);
              state     <= S_READ;
            end
          end
          S_READ: begin
            if (advance) begin
              case (rd_idx)
                2'd0: w_sh[162:81] <= slv_data[113:32];
                2'd1: w_sh[80:0]   <= slv_data[112:32];
                2'd2: z_sh[162:81] <= slv_data[113:32];
                2'd3: z_sh[80:0]   <= slv_data[112:32];
                default: ;
              endcase
              if (rd_idx == 2'd3) begin
                fin_cnt   <= 2'd0;
                host_data <= cmd_word(CMD_FIN);
                state     <= S_FIN;
              end else begin
                rd_idx    <= rd_nxt;
                host_data <= cmd_word(CMD_RD0 | {12'b0, rd_nxt, 2'b00});
              end
            end
          end
          S_FIN: begin
            if (fin_cnt == 2'd3) begin
              wout      <= w_sh;
              zout      <= z_sh;
              done      <= 1'b1;
              busy      <= 1'b0;
              host_oenb <= '1;
              host_data <= '0;
              state     <= S_IDLE;
            end else begin
              fin_cnt <= fin_cnt + 2'd1;
            end
          end
          S_ERR: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bec_la_host.sv
// tb/tb_bec_la_host.sv - randomized scoreboard bench for bec_la_host with a reactive slave model
module tb_bec_la_host;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [162:0] op_w1, op_z1, op_w2, op_z2, op_inv_w0, op_d, op_key;
  logic [127:0] slv_data, host_data, host_oenb;
  logic         busy, done, err;
  logic [2:0]   err_code;
  logic [162:0] wout, zout;

  always #5 clk = ~clk;

  bec_la_host #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
    .op_w1(op_w1), .op_z1(op_z1), .op_w2(op_w2), .op_z2(op_z2),
    .op_inv_w0(op_inv_w0), .op_d(op_d), .op_key(op_key),
    .slv_data(slv_data), .host_data(host_data), .host_oenb(host_oenb),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .wout(wout), .zout(zout)
  );

  typedef struct {
    bit           is_err;
    logic [2:0]   code;
    logic [162:0] w;
    logic [162:0] z;
  } res_t;

  logic [127:0] chunk_q[$];
  res_t         res_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [162:0] ops [7];
  logic [162:0] w_ret = '0, z_ret = '0, last_w = '0, last_z = '0;
  int           blk_chunk = -1;
  int           swap_left = 0;
  int           ab04_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [162:0] rnd163();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[162:0];
  endfunction

  function automatic logic [127:0] noise();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[127:122] = 6'b0;
    return r;
  endfunction

  // Reference: chunk k is half of operand k/2, high half first, tagged with k+1 ones.
  function automatic logic [127:0] exp_chunk(input int k);
    logic [13:0]  tag;
    logic [81:0]  c;
    logic [162:0] op;
    op  = ops[k / 2];
    tag = 14'((1 << (k + 1)) - 1);
    if (k % 2 == 0) c = 82'(op >> 82);
    else            c = op[81:0];
    return {32'h0, tag, c};
  endfunction

  function automatic logic [127:0] slave_resp(input logic [127:0] hd);
    logic [127:0] r;
    logic [31:0]  x;
    int           k;
    r = noise();
    x = $urandom;
    if (hd[95:82] != 14'h0) begin
      k = $countones(hd[95:82]) - 1;
      if (k == blk_chunk) return r;
      if (k < 13) r[127:122] = {x[1:0], 4'(k + 1)};
      else        r[127:122] = 6'b011110;
    end else begin
      case (hd[31:16])
        16'hAB30: r[127:122] = x[2] ? 6'b010000 : {x[1:0], 4'b0001};
        16'hAB41: r[127:122] = 6'b100111;
        16'hAB00: r[127:32]  = {14'h3100, w_ret[162:81]};
        16'hAB04: r[127:32]  = {14'h3200, x[3], w_ret[80:0]};
        16'hAB08: r[127:32]  = {14'h3300, z_ret[162:81]};
        16'hAB0C: r[127:32]  = {14'h3400, x[4], z_ret[80:0]};
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [127:0] seen;
    int           dly;
    seen = '0;
    dly = 0;
    slv_data = noise();
    forever begin
      @(negedge clk);
      if (host_data !== seen) begin
        seen = host_data;
        slv_data = noise();
        dly = $urandom_range(0, 3);
      end else if (dly > 0) begin
        dly--;
      end else if (swap_left > 0 && host_data[95:82] == 14'h0 && host_data[31:16] == 16'hAB04) begin
        slv_data[127:32] = {14'h3300, ~w_ret[162:81]};
        swap_left--;
      end else begin
        slv_data = slave_resp(host_data);
      end
    end
  end

  initial begin
    logic [127:0] prev_hd;
    logic         prev_err;
    logic [127:0] e;
    res_t         r;
    prev_hd = '0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (host_data[95:82] != 14'h0 && host_data !== prev_hd) begin
          if (chunk_q.size() == 0) check("unexpected_chunk", host_data, 0);
          else begin
            e = chunk_q.pop_front();
            check("chunk_word", host_data, e);
            check("chunk_busy_oenb", {busy, host_oenb}, {1'b1, 128'h0});
          end
        end
        if (host_data[95:82] == 14'h0 && host_data[31:16] == 16'hAB04) ab04_cnt++;
        if (done || (err && !prev_err)) begin
          if (res_q.size() == 0) check("unexpected_end", {done, err}, 0);
          else begin
            r = res_q.pop_front();
            check("end_kind", {done, err}, r.is_err ? 2'b01 : 2'b10);
            if (r.is_err) check("err_code", err_code, r.code);
            check("wout", wout, r.w);
            check("zout", zout, r.z);
            check("chunks_left", chunk_q.size(), 0);
            check("end_idle_oenb", {busy, host_oenb}, {1'b0, {128{1'b1}}});
          end
        end
      end
      prev_hd = host_data;
      prev_err = err;
    end
  end

  task automatic issue(input bit fail3);
    res_t r;
    op_w1 = ops[0]; op_z1 = ops[1]; op_w2 = ops[2]; op_z2 = ops[3];
    op_inv_w0 = ops[4]; op_d = ops[5]; op_key = ops[6];
    blk_chunk = fail3 ? 3 : -1;
    for (int k = 0; k < 14; k++)
      if (!fail3 || k <= 3) chunk_q.push_back(exp_chunk(k));
    r.is_err = fail3;
    r.code   = fail3 ? 3'd2 : 3'd0;
    r.w      = fail3 ? last_w : w_ret;
    r.z      = fail3 ? last_z : z_ret;
    res_q.push_back(r);
    if (!fail3) begin
      last_w = w_ret;
      last_z = z_ret;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input bit poke);
    int n;
    n = 0;
    while (!(done || err) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("txn_finished", done | err, 1);
    if (poke && done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_done_ignored", busy, 0);
      repeat (4) @(negedge clk);
      check("still_idle", {busy, host_data}, 0);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic randomize_txn();
    for (int k = 0; k < 7; k++) ops[k] = rnd163();
    w_ret = rnd163();
    z_ret = rnd163();
  endtask

  initial begin
    int n;
    for (int k = 0; k < 7; k++) ops[k] = '0;
    op_w1 = '0; op_z1 = '0; op_w2 = '0; op_z2 = '0;
    op_inv_w0 = '0; op_d = '0; op_key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_host_data", host_data, 0);
    check("reset_oenb", host_oenb, {128{1'b1}});
    check("reset_flags", {busy, done, err, err_code}, 0);
    check("reset_wout", wout, 0);
    check("reset_zout", zout, 0);
    repeat (5) @(negedge clk);
    check("quiet_after_reset", {host_oenb, host_data, busy, done, err}, {{128{1'b1}}, 131'h0});

    ops[0] = 163'h1;
    w_ret  = {163{1'b1}};
    z_ret  = 163'h5;
    issue(1'b0);
    wait_end(1'b0);
    check("golden_wout", wout, {163{1'b1}});
    check("golden_zout", zout, 163'h5);

    for (int t = 0; t < 6; t++) begin
      randomize_txn();
      issue(1'b0);
      wait_end(1'b0);
    end

    randomize_txn();
    issue(1'b0);
    repeat (10) @(negedge clk);
    check("busy_mid_txn", busy, 1);
    op_w1 = rnd163(); op_z1 = rnd163(); op_key = rnd163();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(1'b1);

    randomize_txn();
    swap_left = 8;
    ab04_cnt = 0;
    issue(1'b0);
    wait_end(1'b0);
    check("hold_ab04", ab04_cnt >= 9, 1);

    randomize_txn();
    issue(1'b1);
    wait_end(1'b0);
    check("timeout_state", {err, err_code, busy}, {1'b1, 3'd2, 1'b0});
    check("timeout_wout_kept", wout, last_w);

    randomize_txn();
    issue(1'b0);
    n = 0;
    while (host_data[95:82] != 14'h00FF && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_chunk7", host_data[95:82], 14'h00FF);
    #2 rst = 1'b1;
    #1;
    check("midrst_host_data", host_data, 0);
    check("midrst_oenb", host_oenb, {128{1'b1}});
    check("midrst_flags", {busy, done, err, err_code}, 0);
    check("midrst_wout", wout, 0);
    check("midrst_zout", zout, 0);
    chunk_q.delete();
    res_q.delete();
    last_w = '0;
    last_z = '0;
    @(negedge clk);
    rst = 1'b0;
    randomize_txn();
    issue(1'b0);
    wait_end(1'b0);

    repeat (3) @(negedge clk);
    check("results_drained", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
